// File: rtl/operand_decoder.sv
// rtl/operand_decoder.sv - four-state IEEE-754 single-precision operand classifier and magnitude comparator
module operand_decoder #(
    parameter logic [7:0] SAT_SHIFT = 8'd24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_valid_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic        busy_o,
    output logic        data_valid_o,
    output logic        x_sign_o,
    output logic        y_sign_o,
    output logic [7:0]  x_exp_o,
    output logic [7:0]  y_exp_o,
    output logic [22:0] x_frac_o,
    output logic [22:0] y_frac_o,
    output logic        x_greater_o,
    output logic [7:0]  exp_shift_o,
    output logic        x_infinity_o,
    output logic        y_infinity_o,
    output logic        x_nan_o,
    output logic        y_nan_o,
    output logic        x_zero_o,
    output logic        y_zero_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] x_q;
    logic [31:0] y_q;

    // Field extraction from the captured operands; denormals flush to zero.
    logic [7:0]  x_exp_w;
    logic [7:0]  y_exp_w;
    logic [22:0] x_frac_raw;
    logic [22:0] y_frac_raw;
    logic        x_zero_w;
    logic        y_zero_w;
    logic        x_max_exp_w;
    logic        y_max_exp_w;

    assign x_exp_w     = x_q[30:23];
    assign y_exp_w     = y_q[30:23];
    assign x_frac_raw  = x_q[22:0];
    assign y_frac_raw  = y_q[22:0];
    assign x_zero_w    = (x_exp_w == 8'h00);
    assign y_zero_w    = (y_exp_w == 8'h00);
    assign x_max_exp_w = (x_exp_w == 8'hFF);
    assign y_max_exp_w = (y_exp_w == 8'hFF);

    // Exponent distance from the registered (post-flush) exponents.
    logic [7:0] exp_diff_w;
    assign exp_diff_w = (x_exp_o >= y_exp_o) ? (x_exp_o - y_exp_o) : (y_exp_o - x_exp_o);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b1;
        data_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (data_valid_i) begin
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = COMPARE;
            COMPARE: state_d = DONE;
            DONE: begin
                data_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on the accept edge only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= 32'd0;
            y_q <= 32'd0;
        end else if (state_q == IDLE && data_valid_i) begin
            x_q <= x_i;
            y_q <= y_i;
        end
    end

    // Field and class registers, loaded when leaving DECODE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_sign_o     <= 1'b0;
            y_sign_o     <= 1'b0;
            x_exp_o      <= 8'd0;
            y_exp_o      <= 8'd0;
            x_frac_o     <= 23'd0;
            y_frac_o     <= 23'd0;
            x_infinity_o <= 1'b0;
            y_infinity_o <= 1'b0;
            x_nan_o      <= 1'b0;
            y_nan_o      <= 1'b0;
            x_zero_o     <= 1'b0;
            y_zero_o     <= 1'b0;
        end else if (state_q == DECODE) begin
            x_sign_o     <= x_q[31];
            y_sign_o     <= y_q[31];
            x_exp_o      <= x_exp_w;
            y_exp_o      <= y_exp_w;
            x_frac_o     <= x_zero_w ? 23'd0 : x_frac_raw;
            y_frac_o     <= y_zero_w ? 23'd0 : y_frac_raw;
            x_infinity_o <= x_max_exp_w && (x_frac_raw == 23'd0);
            y_infinity_o <= y_max_exp_w && (y_frac_raw == 23'd0);
            x_nan_o      <= x_max_exp_w && (x_frac_raw != 23'd0);
            y_nan_o      <= y_max_exp_w && (y_frac_raw != 23'd0);
            x_zero_o     <= x_zero_w;
            y_zero_o     <= y_zero_w;
        end
    end

    // Magnitude comparison and saturated shift, loaded when leaving COMPARE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_greater_o <= 1'b0;
            exp_shift_o <= 8'd0;
        end else if (state_q == COMPARE) begin
            x_greater_o <= (x_exp_o > y_exp_o) ||
                           ((x_exp_o == y_exp_o) && (x_frac_o >= y_frac_o));
            exp_shift_o <= (exp_diff_w > SAT_SHIFT) ? SAT_SHIFT : exp_diff_w;
        end
    end

endmodule
